// File: rtl/breakout_game_logic.sv
// Breakout game-state engine: one multi-cycle physics update per FRAME_DONE,
// outputs committed together in the final cycle so the renderer never sees a half-updated frame.
module breakout_game_logic #(
   parameter int PLAY_LEFT    = 16,
   parameter int PLAY_RIGHT   = 784,
   parameter int PLAY_TOP     = 40,
   parameter int BLOCK_X0     = 16,
   parameter int BLOCK_Y0     = 64,
   parameter int PADDLE_Y     = 560,
   parameter int PADDLE_LEN   = 64,
   parameter int FLOOR_Y      = 592,
   parameter int PADDLE_SPEED = 4,
   parameter int BALL_SPEED   = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        FRAME_DONE,
   input  logic        BTN_LEFT,
   input  logic        BTN_RIGHT,
   input  logic        BTN_FIRE,
   output logic [9:0]  PADDLE_X_PIXEL,
   output logic [9:0]  BALL_X_PIXEL,
   output logic [9:0]  BALL_Y_PIXEL,
   output logic [71:0] BLOCK_STATE,
   output logic [1:0]  GAME_MODE
);
   localparam logic [10:0] L_LEFT   = 11'(PLAY_LEFT);
   localparam logic [10:0] L_RIGHT  = 11'(PLAY_RIGHT);
   localparam logic [10:0] L_TOP    = 11'(PLAY_TOP);
   localparam logic [10:0] L_BX0    = 11'(BLOCK_X0);
   localparam logic [10:0] L_BY0    = 11'(BLOCK_Y0);
   localparam logic [10:0] L_PY     = 11'(PADDLE_Y);
   localparam logic [10:0] L_PLEN   = 11'(PADDLE_LEN);
   localparam logic [10:0] L_FLOOR  = 11'(FLOOR_Y);
   localparam logic [10:0] L_PSPD   = 11'(PADDLE_SPEED);
   localparam logic [10:0] L_BSPD   = 11'(BALL_SPEED);
   localparam logic [10:0] PX_MAX   = L_RIGHT - L_PLEN;
   localparam logic [10:0] PX_RST   = ((L_LEFT + L_RIGHT) >> 1) - (L_PLEN >> 1);
   localparam logic [10:0] PARK_DX  = (L_PLEN >> 1) - 11'd4;
   localparam logic [10:0] PARK_Y   = L_PY - 11'd8;

   localparam logic [1:0] M_SERVE = 2'd0;
   localparam logic [1:0] M_PLAY  = 2'd1;
   localparam logic [1:0] M_LOST  = 2'd2;
   localparam logic [1:0] M_WON   = 2'd3;

   typedef enum logic [2:0] {
      S_WAIT, S_PADDLE, S_BALL, S_WALLS, S_CORNER, S_PADDLE_HIT, S_COMMIT
   } state_t;

   state_t      state, state_next;
   logic [1:0]  corner;
   logic [10:0] px, bx, by;
   logic        dx_neg, dy_up;
   logic [71:0] blocks;
   logic [1:0]  mode;
   logic        fire_prev, fire_edge, active, hit;

   logic [10:0] px_dec, px_inc, cx, cy, col_off, row_off, ball_r, ball_b, y_after;
   logic [4:0]  col;
   logic [6:0]  row, blk_idx;
   logic        in_grid, blk_hit, dy_new_up, paddle_hit;

   assign px_dec = px - L_PSPD;
   assign px_inc = px + L_PSPD;

   // Corner k: bit 0 selects the right edge, bit 1 the bottom edge of the sprite.
   assign cx      = corner[0] ? bx + 11'd7 : bx;
   assign cy      = corner[1] ? by + 11'd7 : by;
   assign col_off = cx - L_BX0;
   assign row_off = cy - L_BY0;
   assign col     = 5'(col_off >> 6);
   assign row     = 7'(row_off >> 4);
   assign in_grid = (col < 5'd12) && (row < 7'd6);
   assign blk_idx = 7'(row[2:0]) * 7'd12 + 7'(col[3:0]);
   assign blk_hit = in_grid && blocks[blk_idx];

   assign dy_new_up  = dy_up ^ hit;
   assign ball_r     = bx + 11'd8;
   assign ball_b     = by + 11'd8;
   assign paddle_hit = !dy_new_up && (ball_b >= L_PY) && (ball_b < L_PY + L_BSPD)
                       && (ball_r > px) && (bx < px + L_PLEN);
   assign y_after    = paddle_hit ? PARK_Y : by;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= S_WAIT;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_WAIT:       if (FRAME_DONE) state_next = S_PADDLE;
         S_PADDLE:     state_next = S_BALL;
         S_BALL:       state_next = S_WALLS;
         S_WALLS:      state_next = S_CORNER;
         S_CORNER:     if (corner == 2'd3) state_next = S_PADDLE_HIT;
         S_PADDLE_HIT: state_next = S_COMMIT;
         S_COMMIT:     state_next = S_WAIT;
         default:      state_next = S_WAIT;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         corner <= 2'd0;   px <= PX_RST;   bx <= PX_RST + PARK_DX;   by <= PARK_Y;
         dx_neg <= 1'b0;   dy_up <= 1'b1;  blocks <= '1;             mode <= M_SERVE;
         fire_prev <= 1'b0; fire_edge <= 1'b0; active <= 1'b0;       hit <= 1'b0;
         PADDLE_X_PIXEL <= PX_RST[9:0];
         BALL_X_PIXEL   <= 10'(PX_RST + PARK_DX);
         BALL_Y_PIXEL   <= PARK_Y[9:0];
         BLOCK_STATE    <= '1;
         GAME_MODE      <= M_SERVE;
      end else begin
         case (state)
            S_PADDLE: begin
               fire_prev <= BTN_FIRE;
               fire_edge <= BTN_FIRE & ~fire_prev;
               // Bit 10 of px_dec catches a wrap below zero.
               if (BTN_LEFT && !BTN_RIGHT)
                  px <= (px_dec[10] || px_dec < L_LEFT) ? L_LEFT : px_dec;
               else if (BTN_RIGHT && !BTN_LEFT)
                  px <= (px_inc > PX_MAX) ? PX_MAX : px_inc;
            end
            S_BALL: begin
               active <= (mode == M_PLAY);
               hit    <= 1'b0;
               corner <= 2'd0;
               case (mode)
                  M_SERVE: begin
                     bx <= px + PARK_DX;
                     by <= PARK_Y;
                     if (fire_edge) begin
                        mode <= M_PLAY;  dx_neg <= 1'b0;  dy_up <= 1'b1;
                     end
                  end
                  M_PLAY: begin
                     bx <= dx_neg ? bx - L_BSPD : bx + L_BSPD;
                     by <= dy_up  ? by - L_BSPD : by + L_BSPD;
                  end
                  default: if (fire_edge) begin
                     mode <= M_SERVE;  blocks <= '1;
                     bx <= px + PARK_DX;  by <= PARK_Y;
                  end
               endcase
            end
            S_WALLS: if (active) begin
               if (bx < L_LEFT) begin
                  bx <= L_LEFT;  dx_neg <= 1'b0;
               end else if (ball_r > L_RIGHT) begin
                  bx <= L_RIGHT - 11'd8;  dx_neg <= 1'b1;
               end
               if (by < L_TOP) begin
                  by <= L_TOP;  dy_up <= 1'b0;
               end
            end
            S_CORNER: begin
               corner <= corner + 2'd1;
               if (active && blk_hit) begin
                  blocks[blk_idx] <= 1'b0;
                  hit <= 1'b1;
               end
            end
            S_PADDLE_HIT: if (active) begin
               dy_up <= dy_new_up;
               if (paddle_hit) begin
                  by <= PARK_Y;  dy_up <= 1'b1;
                  dx_neg <= (bx + 11'd4 < px + (L_PLEN >> 1));
               end
               if (y_after >= L_FLOOR)  mode <= M_LOST;
               else if (blocks == '0)   mode <= M_WON;
            end
            S_COMMIT: begin
               PADDLE_X_PIXEL <= px[9:0];
               BALL_X_PIXEL   <= bx[9:0];
               BALL_Y_PIXEL   <= by[9:0];
               BLOCK_STATE    <= blocks;
               GAME_MODE      <= mode;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_breakout_game_logic.sv
// Directed bench for breakout_game_logic: reset, paddle clamps, serve, block hits, walls,
// paddle bounce, floor loss and restart, with hand-computed trajectories.
module tb_breakout_game_logic;
   logic        CLK = 1'b0;
   logic        RESET, FRAME_DONE, BTN_LEFT, BTN_RIGHT, BTN_FIRE;
   logic [9:0]  PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL;
   logic [71:0] BLOCK_STATE;
   logic [1:0]  GAME_MODE;

   int tests = 0;
   int fails = 0;
   logic [71:0] all_ones, minus66, minus71;

   breakout_game_logic dut (
      .CLK(CLK), .RESET(RESET), .FRAME_DONE(FRAME_DONE),
      .BTN_LEFT(BTN_LEFT), .BTN_RIGHT(BTN_RIGHT), .BTN_FIRE(BTN_FIRE),
      .PADDLE_X_PIXEL(PADDLE_X_PIXEL), .BALL_X_PIXEL(BALL_X_PIXEL),
      .BALL_Y_PIXEL(BALL_Y_PIXEL), .BLOCK_STATE(BLOCK_STATE), .GAME_MODE(GAME_MODE)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s got=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_px(input string tag, input int exp);
      check(tag, 72'(PADDLE_X_PIXEL), 72'(exp));
   endtask

   task automatic check_ball(input string tag, input int x, input int y);
      check({tag, "_x"}, 72'(BALL_X_PIXEL), 72'(x));
      check({tag, "_y"}, 72'(BALL_Y_PIXEL), 72'(y));
   endtask

   task automatic check_mode(input string tag, input int exp);
      check(tag, 72'(GAME_MODE), 72'(exp));
   endtask

   // One frame: pulse FRAME_DONE, then sample 10 edges later, when the commit must have landed.
   task automatic run_frame(input logic l, input logic r, input logic f);
      BTN_LEFT = l;  BTN_RIGHT = r;  BTN_FIRE = f;
      @(negedge CLK) FRAME_DONE = 1'b1;
      @(negedge CLK) FRAME_DONE = 1'b0;
      repeat (9) @(posedge CLK);
      #1;
   endtask

   task automatic pulse_reset();
      @(negedge CLK) RESET = 1'b1;
      @(negedge CLK) RESET = 1'b0;
      #1;
   endtask

   initial begin
      all_ones = '1;
      minus66  = all_ones & ~(72'd1 << 66);
      minus71  = all_ones & ~(72'd1 << 71);
      RESET = 1'b1;  FRAME_DONE = 1'b0;
      BTN_LEFT = 1'b0;  BTN_RIGHT = 1'b0;  BTN_FIRE = 1'b0;
      repeat (3) @(negedge CLK);
      RESET = 1'b0;
      #1;
      check_px("rst_px", 368);
      check_ball("rst_ball", 396, 552);
      check("rst_blk", BLOCK_STATE, all_ones);
      check_mode("rst_mode", 0);

      run_frame(1'b0, 1'b1, 1'b0);
      check_px("serve_px", 372);
      check_ball("serve_park", 400, 552);
      check_mode("serve_mode", 0);
      run_frame(1'b0, 1'b0, 1'b1);
      check_mode("fire_mode", 1);
      check_ball("fire_ball", 400, 552);
      run_frame(1'b0, 1'b0, 1'b1);
      check_ball("first_move", 404, 548);

      // Reset while the sequencer is in the corner checks.
      BTN_RIGHT = 1'b1;  BTN_FIRE = 1'b0;
      @(negedge CLK) FRAME_DONE = 1'b1;
      @(negedge CLK) FRAME_DONE = 1'b0;
      repeat (4) @(posedge CLK);
      #1 RESET = 1'b1;
      @(negedge CLK) RESET = 1'b0;
      #1;
      check_px("midrst_px", 368);
      check_ball("midrst_ball", 396, 552);
      check("midrst_blk", BLOCK_STATE, all_ones);
      check_mode("midrst_mode", 0);
      run_frame(1'b0, 1'b0, 1'b0);
      check_px("postrst_px", 368);
      check_mode("postrst_mode", 0);

      for (int k = 1; k <= 100; k++) begin
         run_frame(1'b0, 1'b1, 1'b0);
         check_px("right_sweep", (368 + 4 * k > 720) ? 720 : 368 + 4 * k);
      end
      check_ball("park_right", 748, 552);
      run_frame(1'b1, 1'b1, 1'b0);
      check_px("both_hold", 720);

      // A second FRAME_DONE mid-update must not start another update.
      BTN_LEFT = 1'b1;  BTN_RIGHT = 1'b0;
      @(negedge CLK) FRAME_DONE = 1'b1;
      @(negedge CLK) FRAME_DONE = 1'b0;
      repeat (2) @(negedge CLK);
      FRAME_DONE = 1'b1;
      @(negedge CLK) FRAME_DONE = 1'b0;
      repeat (6) @(posedge CLK);
      #1 check_px("extra_pulse", 716);
      repeat (12) @(posedge CLK);
      #1 check_px("extra_pulse_idle", 716);

      for (int k = 1; k <= 180; k++) begin
         run_frame(1'b1, 1'b0, 1'b0);
         check_px("left_sweep", (716 - 4 * k < 16) ? 16 : 716 - 4 * k);
      end

      // Serve from the far left, clear block 66 on the way up, bounce off the paddle.
      run_frame(1'b0, 1'b0, 1'b1);
      check_mode("a_fire_mode", 1);
      check_ball("a_fire_ball", 44, 552);
      for (int n = 1; n <= 199; n++) begin
         run_frame(1'b0, (n <= 165), 1'b0);
         if (n == 1)   check_ball("a_n1", 48, 548);
         if (n == 98) begin
            check_ball("a_n98", 436, 160);
            check("a_blk98", BLOCK_STATE, all_ones);
         end
         if (n == 99) begin
            check_ball("a_n99", 440, 156);
            check("a_blk99", BLOCK_STATE, minus66);
         end
         if (n == 100) check_ball("a_n100", 444, 160);
         if (n == 165) check_px("a_px165", 676);
         if (n == 184) check_ball("a_wall_r", 776, 496);
         if (n == 198) begin
            check_ball("a_paddle", 720, 552);
            check_mode("a_mode198", 1);
            check("a_blk198", BLOCK_STATE, minus66);
         end
         if (n == 199) begin
            check_ball("a_rebound", 724, 548);
            check_px("a_px199", 676);
         end
      end

      // Serve from centre, clear block 71, just miss the paddle edge and fall to LOST.
      pulse_reset();
      run_frame(1'b0, 1'b0, 1'b1);
      check_mode("b_fire_mode", 1);
      check_ball("b_fire_ball", 396, 552);
      for (int n = 1; n <= 208; n++) begin
         run_frame((n <= 16), 1'b0, 1'b0);
         if (n == 1) begin
            check_ball("b_n1", 400, 548);
            check_px("b_px1", 364);
         end
         if (n == 16)  check_px("b_px16", 304);
         if (n == 96)  check_ball("b_wall_r", 776, 168);
         if (n == 99) begin
            check_ball("b_n99", 764, 156);
            check("b_blk99", BLOCK_STATE, minus71);
         end
         if (n == 198) check_ball("b_edge_miss", 368, 552);
         if (n == 199) check_ball("b_falling", 364, 556);
         if (n == 207) begin
            check_ball("b_n207", 332, 588);
            check_mode("b_mode207", 1);
         end
         if (n == 208) begin
            check_ball("b_floor", 328, 592);
            check_mode("b_lost", 2);
         end
      end

      run_frame(1'b1, 1'b0, 1'b0);
      check_px("lost_px", 300);
      check_ball("lost_frozen", 328, 592);
      check_mode("lost_mode", 2);
      check("lost_blk", BLOCK_STATE, minus71);
      run_frame(1'b0, 1'b0, 1'b1);
      check_mode("restart_mode", 0);
      check("restart_blk", BLOCK_STATE, all_ones);
      check_ball("restart_park", 328, 552);
      run_frame(1'b0, 1'b0, 1'b1);
      check_mode("fire_held", 0);
      run_frame(1'b0, 1'b0, 1'b0);
      check_mode("fire_released", 0);
      run_frame(1'b0, 1'b0, 1'b1);
      check_mode("fire_again", 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
